mips16_core_top: RTL and testbench

MIPS16_CORE_TOP -- requirements
Module: mips16_core_top

---
 rtl/mips16_core_top_if.sv | 42 ++++
 rtl/mips16_core_top.sv | 113 +++++++++++
 tb/tb_mips16_core_top.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips16_core_top_if.sv
// Bus bundle between the MIPS16 core and its instruction memory, register file,
// data memory and self-test logic. master = core side, slave = environment side.
interface mips16_core_top_if #(
  parameter int PC_WIDTH = 8
);
  logic [15:0]         irst_reg_data;
  logic                irst_done;
  logic [15:0]         instruction;
  logic [PC_WIDTH-1:0] pc;
  logic                inst_write_en;
  logic [15:0]         inst_write_data;
  logic                reg_write_en;
  logic [2:0]          reg_write_dest;
  logic [15:0]         reg_write_data;
  logic [2:0]          reg_read_addr_1;
  logic [15:0]         reg_read_data_1;
  logic [2:0]          reg_read_addr_2;
  logic [15:0]         reg_read_data_2;
  logic [15:0]         mem_access_addr;
  logic [15:0]         mem_write_data;
  logic                mem_write_en;
  logic [15:0]         mem_read_data;
  logic [31:0]         rand_data;

  modport master (
    input  irst_reg_data, irst_done, instruction,
    input  reg_read_data_1, reg_read_data_2, mem_read_data,
    output pc, inst_write_en, inst_write_data,
    output reg_write_en, reg_write_dest, reg_write_data,
    output reg_read_addr_1, reg_read_addr_2,
    output mem_access_addr, mem_write_data, mem_write_en, rand_data
  );

  modport slave (
    output irst_reg_data, irst_done, instruction,
    output reg_read_data_1, reg_read_data_2, mem_read_data,
    input  pc, inst_write_en, inst_write_data,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  reg_read_addr_1, reg_read_addr_2,
    input  mem_access_addr, mem_write_data, mem_write_en, rand_data
  );
endinterface

// File: rtl/mips16_core_top.sv
// Single-cycle 16-bit MIPS-like core: one instruction per clock, halts while irst_done=1.
// Optional signature LFSR on rand_data is built only when MIPS16_SIGNATURE_EN is defined.
module mips16_core_top #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  mips16_core_top_if.master   bus
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND  = 4'd3,
    OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SL  = 4'd6,  OP_SR   = 4'd7,
    OP_SRU  = 4'd8,  OP_ADDI = 4'd9, OP_LD  = 4'd10, OP_ST   = 4'd11,
    OP_BZ   = 4'd12, OP_IMW = 4'd13, OP_R14 = 4'd14, OP_R15  = 4'd15
  } opcode_t;

  opcode_t                    op;
  logic [2:0]                 rd;
  logic [2:0]                 rs1;
  logic [2:0]                 rs2;
  logic signed [15:0]         imm_s;
  logic signed [15:0]         src1_s;
  logic [15:0]                src2;
  logic [3:0]                 shamt;
  logic [15:0]                eff_addr;
  logic [15:0]                alu_res;
  logic                       active;
  logic                       writes_rd;
  logic                       bz_taken;
  logic signed [PC_WIDTH-1:0] imm_pc;
  logic [PC_WIDTH-1:0]        pc_q;
  logic [PC_WIDTH-1:0]        pc_d;

  always_comb begin
    op        = opcode_t'(bus.instruction[15:12]);
    rd        = bus.instruction[11:9];
    rs1       = bus.instruction[8:6];
    rs2       = bus.instruction[5:3];
    imm_s     = 16'(signed'(bus.instruction[5:0]));
    src1_s    = signed'(bus.reg_read_data_1);
    src2      = bus.reg_read_data_2;
    shamt     = src2[3:0];
    eff_addr  = bus.reg_read_data_1 + imm_s;
    // Nothing architectural changes while in reset or while the self-test holds the core.
    active    = !rst && !bus.irst_done;
    writes_rd = (op >= OP_ADD) && (op <= OP_LD) && (rd != 3'd0);
    bz_taken  = (op == OP_BZ) && (bus.reg_read_data_1 == 16'd0);
    imm_pc    = PC_WIDTH'(imm_s);

    alu_res = 16'd0;
    case (op)
      OP_ADD:  alu_res = bus.reg_read_data_1 + src2;
      OP_SUB:  alu_res = bus.reg_read_data_1 - src2;
      OP_AND:  alu_res = bus.reg_read_data_1 & src2;
      OP_OR:   alu_res = bus.reg_read_data_1 | src2;
      OP_XOR:  alu_res = bus.reg_read_data_1 ^ src2;
      OP_SL:   alu_res = bus.reg_read_data_1 << shamt;
      OP_SR:   alu_res = 16'(src1_s >>> shamt);
      OP_SRU:  alu_res = bus.reg_read_data_1 >> shamt;
      OP_ADDI: alu_res = eff_addr;
      OP_LD:   alu_res = bus.mem_read_data;
      default: alu_res = 16'd0;
    endcase

    bus.pc              = pc_q;
    bus.reg_read_addr_1 = rs1;
    bus.reg_read_addr_2 = (op == OP_ST) ? rd : rs2;
    bus.reg_write_en    = active && writes_rd;
    bus.reg_write_dest  = rd;
    bus.reg_write_data  = alu_res;
    bus.mem_access_addr = ((op == OP_LD) || (op == OP_ST)) ? eff_addr : 16'd0;
    bus.mem_write_en    = active && (op == OP_ST);
    bus.mem_write_data  = src2;
    bus.inst_write_en   = active && (op == OP_IMW);
    bus.inst_write_data = bus.reg_read_data_1;

    pc_d = pc_q;
    if (rst) begin
      pc_d = '0;
    end else if (!bus.irst_done) begin
      pc_d = pc_q + PC_WIDTH'(1) + (bz_taken ? imm_pc : '0);
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

`ifdef MIPS16_SIGNATURE_EN
  logic [31:0] rand_q;
  logic [31:0] rand_d;

  always_comb begin
    rand_d = rand_q;
    if (rst) begin
      rand_d = 32'h0000_0001;
    end else if (!bus.irst_done) begin
      rand_d = {rand_q[30:0], rand_q[31] ^ rand_q[21] ^ rand_q[1] ^ rand_q[0]}
             ^ {16'h0000, bus.irst_reg_data};
    end
  end

  always_ff @(posedge clk) begin
    rand_q <= rand_d;
  end

  assign bus.rand_data = rand_q;
`else
  assign bus.rand_data = 32'd0;
`endif

endmodule

// File: tb/tb_mips16_core_top.sv
// Scoreboard bench for mips16_core_top: directed programs then random instructions,
// checked against an architectural model of the instruction set.
module tb_mips16_core_top;

  localparam int PW = 8;

  logic clk;
  logic rst;

  mips16_core_top_if #(.PC_WIDTH(PW)) ifc ();

  mips16_core_top #(.PC_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: register file and data memory the core talks to.
  logic [15:0] env_rf [8];
  logic [15:0] env_dm [256];

  assign ifc.reg_read_data_1 = env_rf[ifc.reg_read_addr_1];
  assign ifc.reg_read_data_2 = env_rf[ifc.reg_read_addr_2];
  assign ifc.mem_read_data   = env_dm[ifc.mem_access_addr[7:0]];

  always @(posedge clk) begin
    if (ifc.reg_write_en) env_rf[ifc.reg_write_dest] <= ifc.reg_write_data;
    if (ifc.mem_write_en) env_dm[ifc.mem_access_addr[7:0]] <= ifc.mem_write_data;
  end

  // Architectural reference model.
  logic [15:0] m_rf [8];
  logic [15:0] m_dm [256];
  logic [7:0]  m_pc;
  logic [31:0] m_rnd;
  bit          m_known;

  typedef struct {
    bit          known;
    logic [7:0]  pc;
    logic [31:0] rnd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    bit          rwe;
    logic [2:0]  rdst;
    logic [15:0] rdat;
    bit          mwe;
    logic [15:0] maddr;
    logic [15:0] mdat;
    bit          iwe;
    logic [15:0] idat;
  } exp_t;

  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int low6);
    logic [15:0] w;
    w = {4'(op), 3'(rd), 3'(rs1), 6'(low6)};
    return w;
  endfunction

  task automatic model_step(input bit r, input bit d, input logic [15:0] sd,
                            input logic [15:0] ins, output exp_t e);
    int          op;
    int          rd, rs1, rs2, sh;
    logic [15:0] a, b, c, imm, ea, res;
    bit          run;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:9]);
    rs1 = int'(ins[8:6]);
    rs2 = int'(ins[5:3]);
    imm = {{10{ins[5]}}, ins[5:0]};
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    c   = m_rf[rd];
    sh  = int'(b[3:0]);
    ea  = a + imm;
    run = !r && !d;
    case (op)
      1: res = a + b;
      2: res = a - b;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = 16'(a * (2 ** sh));
      7: res = 16'((a >> sh) | (a[15] ? ~(16'hFFFF >> sh) : 16'h0000));
      8: res = a >> sh;
      9: res = a + imm;
      10: res = m_dm[ea[7:0]];
      default: res = 16'h0000;
    endcase
    e.known = m_known;
    e.pc    = m_pc;
    e.rnd   = m_rnd;
    e.ra1   = 3'(rs1);
    e.ra2   = (op == 11) ? 3'(rd) : 3'(rs2);
    e.rwe   = run && (op >= 1) && (op <= 10) && (rd != 0);
    e.rdst  = 3'(rd);
    e.rdat  = res;
    e.mwe   = run && (op == 11);
    e.maddr = (op == 10 || op == 11) ? ea : 16'h0000;
    e.mdat  = c;
    e.iwe   = run && (op == 13);
    e.idat  = a;
    if (e.rwe) m_rf[rd] = res;
    if (e.mwe) m_dm[ea[7:0]] = c;
    if (r) begin
      m_pc    = 8'd0;
      m_known = 1'b1;
`ifdef MIPS16_SIGNATURE_EN
      m_rnd   = 32'h0000_0001;
`endif
    end else if (!d) begin
      m_pc = m_pc + 8'd1 + ((op == 12 && a == 16'h0000) ? imm[7:0] : 8'd0);
`ifdef MIPS16_SIGNATURE_EN
      m_rnd = {m_rnd[30:0], m_rnd[31] ^ m_rnd[21] ^ m_rnd[1] ^ m_rnd[0]} ^ {16'h0000, sd};
`endif
    end
  endtask

  task automatic step(input bit r, input bit d, input logic [15:0] sd, input logic [15:0] ins);
    exp_t e;
    @(negedge clk);
    rst               = r;
    ifc.irst_done     = d;
    ifc.irst_reg_data = sd;
    ifc.instruction   = ins;
    model_step(r, d, sd, ins, e);
    sb_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs against the queued expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ra1", 32'(ifc.reg_read_addr_1), 32'(e.ra1));
        chk("ra2", 32'(ifc.reg_read_addr_2), 32'(e.ra2));
        chk("reg_we", 32'(ifc.reg_write_en), 32'(e.rwe));
        if (e.rwe) begin
          chk("reg_dest", 32'(ifc.reg_write_dest), 32'(e.rdst));
          chk("reg_data", 32'(ifc.reg_write_data), 32'(e.rdat));
        end
        chk("mem_addr", 32'(ifc.mem_access_addr), 32'(e.maddr));
        chk("mem_we", 32'(ifc.mem_write_en), 32'(e.mwe));
        if (e.mwe) chk("mem_data", 32'(ifc.mem_write_data), 32'(e.mdat));
        chk("inst_we", 32'(ifc.inst_write_en), 32'(e.iwe));
        if (e.iwe) chk("inst_data", 32'(ifc.inst_write_data), 32'(e.idat));
        if (e.known) begin
          chk("pc", 32'(ifc.pc), 32'(e.pc));
          chk("rand", ifc.rand_data, e.rnd);
        end
      end
    end
  end

  initial begin
    logic [7:0]  held_pc;
    logic [31:0] held_rnd;
    rst               = 1'b1;
    ifc.irst_done     = 1'b0;
    ifc.irst_reg_data = 16'h0000;
    ifc.instruction   = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      env_rf[i] = 16'h0000;
      m_rf[i]   = 16'h0000;
    end
    for (int i = 0; i < 256; i++) begin
      env_dm[i] = 16'h0000;
      m_dm[i]   = 16'h0000;
    end
    m_pc    = 8'd0;
    m_rnd   = 32'd0;
    m_known = 1'b0;

    // Reset with a store-like instruction present: no writes allowed.
    step(1'b1, 1'b0, 16'h0000, enc(11, 1, 0, 4));
    #3;
    chk("rst_reg_we", 32'(ifc.reg_write_en), 32'd0);
    chk("rst_mem_we", 32'(ifc.mem_write_en), 32'd0);
    chk("rst_inst_we", 32'(ifc.inst_write_en), 32'd0);

    step(1'b0, 1'b0, 16'h0000, enc(9, 1, 0, 5));
    #3;
    chk("rst_pc", 32'(ifc.pc), 32'd0);
`ifdef MIPS16_SIGNATURE_EN
    chk("rst_rand", ifc.rand_data, 32'h0000_0001);
`else
    chk("rand_const", ifc.rand_data, 32'd0);
`endif
    step(1'b0, 1'b0, 16'h0000, enc(9, 2, 0, 3));
    step(1'b0, 1'b0, 16'h0000, {4'd2, 3'd3, 3'd1, 3'd2, 3'd0});
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("sub_pc", 32'(ifc.pc), 32'd3);
    chk("sub_r3", 32'(env_rf[3]), 32'd2);

    step(1'b0, 1'b0, 16'h0000, enc(11, 1, 0, 4));
    #3;
    chk("st_we", 32'(ifc.mem_write_en), 32'd1);
    chk("st_addr", 32'(ifc.mem_access_addr), 32'd4);
    chk("st_data", 32'(ifc.mem_write_data), 32'd5);
    step(1'b0, 1'b0, 16'h0000, enc(10, 4, 0, 4));
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("ld_r4", 32'(env_rf[4]), 32'd5);

    for (int i = 0; i < 20 && m_pc != 8'd10; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'hC03F);
    step(1'b0, 1'b0, 16'h0000, 16'hC042);
    #3;
    chk("bz_self", 32'(ifc.pc), 32'd10);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("bz_not_taken", 32'(ifc.pc), 32'd11);

    env_rf[1] = 16'h9041;
    m_rf[1]   = 16'h9041;
    for (int i = 0; i < 20 && m_pc != 8'd20; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 16'hD040);
    #3;
    chk("imw_we", 32'(ifc.inst_write_en), 32'd1);
    chk("imw_data", 32'(ifc.inst_write_data), 32'h9041);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("imw_pulse", 32'(ifc.inst_write_en), 32'd0);

    // Halt: pc and signature frozen, no writes.
    held_pc  = ifc.pc;
    held_rnd = ifc.rand_data;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, enc(9, 5, 0, 7));
    #3;
    chk("halt_pc", 32'(ifc.pc), 32'(held_pc + 8'd1));
    chk("halt_rand", ifc.rand_data, m_rnd);
    chk("halt_reg_we", 32'(ifc.reg_write_en), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    #3;
    chk("resume_pc", 32'(ifc.pc), 32'(held_pc + 8'd1));

    // Random instruction stream with occasional resets and halts.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 16'($urandom));
    end
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    #5;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
